// File: rtl/pe_gen2.sv
// Systolic-array processing element with weight-stationary and output-stationary dataflows.
// Computes the MAC in a widened domain with optional saturation and a sticky overflow flag.
module pe_gen2 #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SAT_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pe_enabled,
  input  logic              pe_os_mode,
  input  logic              pe_signed_in,
  input  logic [ACC_W-1:0]  pe_psum_in,
  input  logic [DATA_W-1:0] pe_weight_in,
  input  logic              pe_accept_w_in,
  input  logic [DATA_W-1:0] pe_input_in,
  input  logic              pe_valid_in,
  input  logic              pe_switch_in,
  input  logic              pe_drain_in,
  output logic [ACC_W-1:0]  pe_psum_out,
  output logic [DATA_W-1:0] pe_weight_out,
  output logic [DATA_W-1:0] pe_input_out,
  output logic              pe_valid_out,
  output logic              pe_switch_out,
  output logic              pe_drain_out,
  output logic              pe_ovf_out
);

  localparam int PROD_W = 2*DATA_W + 1;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  psum_q, psum_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] active_q, active_d;
  logic [DATA_W-1:0] weightOut_q, weightOut_d;
  logic [DATA_W-1:0] inputOut_q, inputOut_d;
  logic              validOut_q, validOut_d;
  logic              switchOut_q, switchOut_d;
  logic              drainOut_q, drainOut_d;
  logic              ovf_q, ovf_d;
  logic              mode_q;

  logic [DATA_W-1:0] weightSel;
  logic              extA, extB;
  logic [PROD_W-1:0] opA, opB, prod;
  logic [ACC_W:0]    prodWide, addendWide, sumWide;
  logic [ACC_W-1:0]  addend, sumRes;
  logic              sumOvf;

  // Operands are extended to the product width so the truncated multiply is exact.
  assign weightSel = pe_os_mode ? pe_weight_in : active_q;
  assign extA      = pe_signed_in & pe_input_in[DATA_W-1];
  assign extB      = pe_signed_in & weightSel[DATA_W-1];
  assign opA       = {{(PROD_W-DATA_W){extA}}, pe_input_in};
  assign opB       = {{(PROD_W-DATA_W){extB}}, weightSel};
  assign prod      = opA * opB;

  assign addend     = pe_os_mode ? acc_q : pe_psum_in;
  assign prodWide   = {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
  assign addendWide = {addend[ACC_W-1], addend};
  assign sumWide    = addendWide + prodWide;
  assign sumOvf     = sumWide[ACC_W] ^ sumWide[ACC_W-1];

  always_comb begin
    sumRes = sumWide[ACC_W-1:0];
    if (sumOvf && (SAT_EN != 0)) begin
      sumRes = sumWide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_comb begin
    acc_d       = acc_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    psum_d      = psum_q;
    weightOut_d = '0;
    inputOut_d  = pe_valid_in ? pe_input_in : inputOut_q;
    validOut_d  = pe_valid_in;
    switchOut_d = pe_switch_in;
    drainOut_d  = pe_drain_in;
    ovf_d       = ovf_q;
    // A dataflow switch flushes all per-mode state and drops this cycle's traffic.
    if (pe_os_mode != mode_q) begin
      acc_d    = '0;
      shadow_d = '0;
      active_d = '0;
      psum_d   = '0;
    end else if (!pe_os_mode) begin
      if (pe_accept_w_in) begin
        shadow_d    = pe_weight_in;
        weightOut_d = pe_weight_in;
      end
      if (pe_switch_in) begin
        active_d = shadow_q;
      end
      if (pe_valid_in) begin
        psum_d = sumRes;
        ovf_d  = ovf_q | sumOvf;
      end else begin
        psum_d = '0;
      end
    end else begin
      if (pe_valid_in) begin
        weightOut_d = pe_weight_in;
      end
      if (pe_drain_in) begin
        psum_d = acc_q;
        acc_d  = pe_valid_in ? prodWide[ACC_W-1:0] : '0;
      end else begin
        psum_d = pe_psum_in;
        if (pe_valid_in) begin
          acc_d = sumRes;
          ovf_d = ovf_q | sumOvf;
        end
      end
    end
  end

  // The mode is tracked through reset so release never looks like a mode change.
  always_ff @(posedge clk) begin
    mode_q <= pe_os_mode;
    if (rst || !pe_enabled) begin
      acc_q       <= '0;
      psum_q      <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      weightOut_q <= '0;
      inputOut_q  <= '0;
      validOut_q  <= 1'b0;
      switchOut_q <= 1'b0;
      drainOut_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      psum_q      <= psum_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      weightOut_q <= weightOut_d;
      inputOut_q  <= inputOut_d;
      validOut_q  <= validOut_d;
      switchOut_q <= switchOut_d;
      drainOut_q  <= drainOut_d;
      ovf_q       <= ovf_d;
    end
  end

  assign pe_psum_out   = psum_q;
  assign pe_weight_out = weightOut_q;
  assign pe_input_out  = inputOut_q;
  assign pe_valid_out  = validOut_q;
  assign pe_switch_out = switchOut_q;
  assign pe_drain_out  = drainOut_q;
  assign pe_ovf_out    = ovf_q;

endmodule

// File: tb/tb_pe_gen2.sv
// Self-checking bench for pe_gen2: directed scenarios from the requirements plus
// randomized traffic compared against an integer-arithmetic reference model.
module tb_pe_gen2;

  localparam int     DW     = 8;
  localparam int     AW     = 32;
  localparam int     SAT    = 1;
  localparam longint MAXV   = 64'sd2147483647;
  localparam longint MINV   = -64'sd2147483648;
  localparam longint RANGE  = 64'sd4294967296;

  logic          clk = 1'b0;
  logic          rst, pe_enabled, pe_os_mode, pe_signed_in;
  logic [AW-1:0] pe_psum_in;
  logic [DW-1:0] pe_weight_in, pe_input_in;
  logic          pe_accept_w_in, pe_valid_in, pe_switch_in, pe_drain_in;
  logic [AW-1:0] pe_psum_out;
  logic [DW-1:0] pe_weight_out, pe_input_out;
  logic          pe_valid_out, pe_switch_out, pe_drain_out, pe_ovf_out;

  int testCount = 0;
  int failCount = 0;

  // Reference model state, kept as plain integers.
  longint        mAcc = 0, mPsum = 0;
  logic [DW-1:0] mShadow = '0, mActive = '0, mWOut = '0, mInOut = '0;
  logic          mValidO = 0, mSwO = 0, mDrO = 0, mOvf = 0, mMode = 0;

  pe_gen2 #(.DATA_W(DW), .ACC_W(AW), .SAT_EN(SAT)) dut (
    .clk(clk), .rst(rst), .pe_enabled(pe_enabled), .pe_os_mode(pe_os_mode),
    .pe_signed_in(pe_signed_in), .pe_psum_in(pe_psum_in), .pe_weight_in(pe_weight_in),
    .pe_accept_w_in(pe_accept_w_in), .pe_input_in(pe_input_in), .pe_valid_in(pe_valid_in),
    .pe_switch_in(pe_switch_in), .pe_drain_in(pe_drain_in), .pe_psum_out(pe_psum_out),
    .pe_weight_out(pe_weight_out), .pe_input_out(pe_input_out), .pe_valid_out(pe_valid_out),
    .pe_switch_out(pe_switch_out), .pe_drain_out(pe_drain_out), .pe_ovf_out(pe_ovf_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic longint opVal(input logic [DW-1:0] x, input logic s);
    if (s) return longint'($signed(x));
    return longint'(x);
  endfunction

  function automatic longint satAdd(input longint a, input longint b, output logic ov);
    longint s;
    s  = a + b;
    ov = 1'b0;
    if (s > MAXV) begin
      ov = 1'b1;
      return (SAT != 0) ? MAXV : s - RANGE;
    end
    if (s < MINV) begin
      ov = 1'b1;
      return (SAT != 0) ? MINV : s + RANGE;
    end
    return s;
  endfunction

  // Advances the model by one clock edge using the inputs currently applied.
  task automatic modelStep();
    longint prod, psIn;
    logic   ov;
    logic [DW-1:0] oldShadow;
    if (rst || !pe_enabled) begin
      mAcc = 0; mPsum = 0; mShadow = '0; mActive = '0; mWOut = '0; mInOut = '0;
      mValidO = 0; mSwO = 0; mDrO = 0; mOvf = 0; mMode = pe_os_mode;
      return;
    end
    psIn    = longint'($signed(pe_psum_in));
    mValidO = pe_valid_in;
    mSwO    = pe_switch_in;
    mDrO    = pe_drain_in;
    if (pe_valid_in) mInOut = pe_input_in;
    mWOut = '0;
    if (pe_os_mode != mMode) begin
      mAcc = 0; mShadow = '0; mActive = '0; mPsum = 0;
    end else if (!pe_os_mode) begin
      oldShadow = mShadow;
      if (pe_accept_w_in) begin
        mShadow = pe_weight_in;
        mWOut   = pe_weight_in;
      end
      if (pe_valid_in) begin
        prod  = opVal(pe_input_in, pe_signed_in) * opVal(mActive, pe_signed_in);
        mPsum = satAdd(psIn, prod, ov);
        if (ov) mOvf = 1'b1;
      end else begin
        mPsum = 0;
      end
      if (pe_switch_in) mActive = oldShadow;
    end else begin
      prod = opVal(pe_input_in, pe_signed_in) * opVal(pe_weight_in, pe_signed_in);
      if (pe_valid_in) mWOut = pe_weight_in;
      if (pe_drain_in) begin
        mPsum = mAcc;
        mAcc  = pe_valid_in ? prod : 0;
      end else begin
        mPsum = psIn;
        if (pe_valid_in) begin
          mAcc = satAdd(mAcc, prod, ov);
          if (ov) mOvf = 1'b1;
        end
      end
    end
    mMode = pe_os_mode;
  endtask

  task automatic checkAll();
    checkOutput("psum_out",   longint'($signed(pe_psum_out)), mPsum);
    checkOutput("weight_out", longint'(pe_weight_out), longint'(mWOut));
    checkOutput("input_out",  longint'(pe_input_out),  longint'(mInOut));
    checkOutput("valid_out",  longint'(pe_valid_out),  longint'(mValidO));
    checkOutput("switch_out", longint'(pe_switch_out), longint'(mSwO));
    checkOutput("drain_out",  longint'(pe_drain_out),  longint'(mDrO));
    checkOutput("ovf_out",    longint'(pe_ovf_out),    longint'(mOvf));
  endtask

  // One clock: update the model from the applied inputs, clock the DUT, compare.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic idle();
    pe_psum_in = '0; pe_weight_in = '0; pe_input_in = '0;
    pe_accept_w_in = 0; pe_valid_in = 0; pe_switch_in = 0; pe_drain_in = 0;
  endtask

  task automatic loadWeight(input logic [DW-1:0] w);
    idle(); pe_accept_w_in = 1; pe_weight_in = w; applyStimulus();
    idle(); pe_switch_in = 1; applyStimulus();
  endtask

  task automatic macWs(input logic [DW-1:0] x, input logic [AW-1:0] ps);
    idle(); pe_valid_in = 1; pe_input_in = x; pe_psum_in = ps; applyStimulus();
  endtask

  task automatic beatOs(input logic [DW-1:0] x, input logic [DW-1:0] w, input logic dr);
    idle(); pe_valid_in = 1; pe_input_in = x; pe_weight_in = w; pe_drain_in = dr; applyStimulus();
  endtask

  initial begin
    rst = 1; pe_enabled = 1; pe_os_mode = 0; pe_signed_in = 1; idle();
    pe_valid_in = 1; pe_input_in = 8'h11; pe_drain_in = 1;
    applyStimulus(); applyStimulus();
    checkOutput("reset_psum", longint'(pe_psum_out), 0);
    checkOutput("reset_valid", longint'(pe_valid_out), 0);
    rst = 0;

    // Signed WS MAC: 100 + 5*(-3).
    loadWeight(8'hFD);
    macWs(8'd5, 32'd100);
    checkOutput("ws_signed_psum", longint'($signed(pe_psum_out)), 85);

    // 0xFF * 2 as unsigned and as signed.
    loadWeight(8'hFF);
    pe_signed_in = 0; macWs(8'h02, 32'd0);
    checkOutput("ws_unsigned_psum", longint'($signed(pe_psum_out)), 510);
    pe_signed_in = 1; macWs(8'h02, 32'd0);
    checkOutput("ws_signed_neg_psum", longint'($signed(pe_psum_out)), -2);

    // Same-edge accept and switch copies the old shadow.
    loadWeight(8'd4);
    idle(); pe_accept_w_in = 1; pe_weight_in = 8'd9; pe_switch_in = 1; applyStimulus();
    macWs(8'd1, 32'd0);
    checkOutput("old_shadow_used", longint'($signed(pe_psum_out)), 4);
    idle(); pe_switch_in = 1; applyStimulus();
    macWs(8'd1, 32'd0);
    checkOutput("new_shadow_used", longint'($signed(pe_psum_out)), 9);

    // Positive saturation and sticky overflow.
    loadWeight(8'd127);
    macWs(8'd127, 32'h7FFF_FFF0);
    checkOutput("sat_psum", longint'(pe_psum_out), 64'h7FFF_FFFF);
    checkOutput("sat_ovf", longint'(pe_ovf_out), 1);
    for (int i = 0; i < 3; i++) begin
      idle(); applyStimulus();
      checkOutput("ovf_sticky", longint'(pe_ovf_out), 1);
    end
    rst = 1; idle(); applyStimulus(); rst = 0;
    checkOutput("ovf_cleared", longint'(pe_ovf_out), 0);

    // OS accumulation, drain, and drain overlapping the next tile.
    pe_os_mode = 1; idle(); applyStimulus();
    beatOs(8'd1, 8'd2, 0); beatOs(8'd3, 8'd4, 0); beatOs(8'd5, 8'd6, 0); beatOs(8'd7, 8'd8, 0);
    beatOs(8'd2, 8'd2, 1);
    checkOutput("os_drain_psum", longint'($signed(pe_psum_out)), 100);
    idle(); pe_drain_in = 1; applyStimulus();
    checkOutput("os_acc_after_overlap", longint'($signed(pe_psum_out)), 4);

    // Reset in the middle of an OS accumulation.
    beatOs(8'd3, 8'd3, 0); beatOs(8'd4, 8'd4, 0);
    rst = 1; beatOs(8'd5, 8'd5, 0);
    checkOutput("midrst_psum",   longint'(pe_psum_out),   0);
    checkOutput("midrst_weight", longint'(pe_weight_out), 0);
    checkOutput("midrst_input",  longint'(pe_input_out),  0);
    checkOutput("midrst_valid",  longint'(pe_valid_out),  0);
    rst = 0;
    idle(); pe_drain_in = 1; applyStimulus();
    checkOutput("drain_after_rst", longint'($signed(pe_psum_out)), 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      idle();
      rst            = ($urandom_range(0, 39) == 0);
      pe_enabled     = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 49) == 0) pe_os_mode = ~pe_os_mode;
      pe_signed_in   = $urandom_range(0, 1);
      pe_weight_in   = DW'($urandom);
      pe_input_in    = DW'($urandom);
      pe_accept_w_in = ($urandom_range(0, 9) < 3);
      pe_valid_in    = ($urandom_range(0, 9) < 7);
      pe_switch_in   = ($urandom_range(0, 9) < 2);
      pe_drain_in    = ($urandom_range(0, 9) < 2);
      case ($urandom_range(0, 3))
        0:       pe_psum_in = 32'h7FFF_C000 + ($urandom % 32'h4000);
        1:       pe_psum_in = 32'h8000_0000 + ($urandom % 32'h4000);
        default: pe_psum_in = AW'($urandom_range(0, 2000)) - 32'd1000;
      endcase
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pe_gen2.md
PE_GEN2 -- requirements
Module: pe_gen2

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning operand width for input and weight.
REQ-002 SHALL have parameter ACC_W, default 32, meaning partial-sum/accumulator width; ACC_W >= 2*DATA_W+1.
REQ-003 SHALL have parameter SAT_EN, default 1, meaning 1 = saturating accumulate, 0 = two's-complement wrap.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 pe_enabled  in  1  0 = synchronous clear identical to rst.
REQ-007 pe_os_mode  in  1  0 = weight-stationary (WS), 1 = output-stationary (OS).
REQ-008 pe_signed_in  in  1  1 = operands signed, 0 = operands unsigned.
REQ-009 pe_psum_in  in  ACC_W  north partial sum (WS) / south drain chain input (OS).
REQ-010 pe_weight_in  in  DATA_W  north weight.
REQ-011 pe_accept_w_in  in  1  WS shadow-weight load strobe.
REQ-012 pe_input_in  in  DATA_W  west activation.
REQ-013 pe_valid_in  in  1  west data valid.
REQ-014 pe_switch_in  in  1  WS shadow->active weight swap.
REQ-015 pe_drain_in  in  1  OS accumulator drain strobe.
REQ-016 pe_psum_out  out  ACC_W  south partial sum / drained result.
REQ-017 pe_weight_out, pe_input_out  out  DATA_W  forwarded weight / activation.
REQ-018 pe_valid_out, pe_switch_out, pe_drain_out  out  1  forwarded controls.
REQ-019 pe_ovf_out  out  1  sticky overflow flag.

Function
REQ-020 Product SHALL be formed at 2*DATA_W+1 bits: operands sign-extended if pe_signed_in=1, zero-extended otherwise.
REQ-021 Sum SHALL be computed at ACC_W+1 bits; on overflow, SAT_EN=1 clamps to signed ACC_W max/min, SAT_EN=0 keeps low ACC_W bits; either way pe_ovf_out is set and held until clear.
REQ-022 pe_valid_out, pe_switch_out, pe_drain_out SHALL be the respective inputs delayed exactly 1 cycle, in both modes.
REQ-023 pe_input_out SHALL register pe_input_in when pe_valid_in=1, else hold.
REQ-024 WS: pe_accept_w_in=1 loads shadow <= pe_weight_in and pe_weight_out <= pe_weight_in; else pe_weight_out <= 0.
REQ-025 WS: pe_switch_in=1 copies shadow -> active on that edge; same-edge accept+switch copies the OLD shadow (new weight visible only after a later switch).
REQ-026 WS: pe_valid_in=1 gives pe_psum_out <= pe_psum_in + input*active (1-cycle latency); pe_valid_in=0 gives pe_psum_out <= 0.
REQ-027 OS: pe_valid_in=1 gives acc <= acc + input*pe_weight_in and pe_weight_out <= pe_weight_in; else acc holds, pe_weight_out <= 0.
REQ-028 OS: pe_drain_in=1 gives pe_psum_out <= acc and acc <= 0, or acc <= product when pe_valid_in=1 on the same edge (next tile starts without a bubble).
REQ-029 OS: pe_drain_in=0 gives pe_psum_out <= pe_psum_in (1-cycle drain chain pass-through).
REQ-030 A pe_os_mode change SHALL clear acc, shadow, active and pe_psum_out on that edge; traffic in that cycle is discarded.
REQ-031 Shadow and active weights SHALL be unused in OS mode; acc SHALL be unused in WS mode.

Reset
REQ-032 rst=1 or pe_enabled=0 SHALL, on the clock edge, zero all outputs, acc, shadow, active and pe_ovf_out; this holds mid-operation too.
REQ-033 The first cycle after release SHALL behave as a fresh start, with no residual valid, drain or weight.

Verification
REQ-034 WS signed, DATA_W=8: load w=-3, then switch, then input=5, valid=1, psum_in=100 -> psum_out=85 one cycle later.
REQ-035 WS unsigned: w=0xFF, input=0x02, psum_in=0 -> psum_out=510; the same operands with signed=1 -> -2.
REQ-036 OS: four valid beats (in,w)=(1,2),(3,4),(5,6),(7,8), then drain -> psum_out=100; a drain with valid (2,2) on the same edge leaves acc=4.
REQ-037 SAT_EN=1, ACC_W=32: psum_in=0x7FFFFFF0, product=+127*127 -> psum_out=0x7FFFFFFF and ovf=1 until rst.
REQ-038 Same-edge accept(w=9)+switch with old shadow=4 -> next MAC uses 4; after a second switch it uses 9.
REQ-039 Mid-OS-accumulation rst pulse -> the following drain outputs 0, and all outputs read 0 during reset.
